// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty flags and error pulses.
// Latency: write-to-visible 1 cycle; read data 0 cycles (SHOWAHEAD=1) or 1 cycle (SHOWAHEAD=0).
// Backpressure: producer watches full/almost_full; a rejected wr/rd only raises overflow/underflow.
module fifo_param #(
  parameter int B         = 8,
  parameter int W         = 4,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 4,
  parameter int SHOWAHEAD = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int         DEPTH   = 1 << W;
  localparam logic [W:0] L_DEPTH = (W+1)'(DEPTH);
  localparam logic [W:0] L_AF    = (W+1)'(AF_LEVEL);
  localparam logic [W:0] L_AE    = (W+1)'(AE_LEVEL);

  // Storage is intentionally never cleared; only pointers and count are reset.
  logic [B-1:0] r_mem [DEPTH];

  logic [W-1:0] r_wr_ptr;
  logic [W-1:0] r_rd_ptr;
  logic [W:0]   r_count;
  logic         r_empty;
  logic         r_full;
  logic         r_almost_empty;
  logic         r_almost_full;
  logic         r_overflow;
  logic         r_underflow;

  logic         w_wr_acc;
  logic         w_rd_acc;
  logic         w_ovf;
  logic         w_udf;
  logic [W:0]   w_count_nxt;

  // Accept decisions use the registered empty/full of the current cycle.
  // When full, a simultaneous read frees the slot the write lands in, so the
  // write is accepted; when empty, the read cannot be served even with a write.
  always_comb begin
    w_wr_acc    = 1'b0;
    w_rd_acc    = 1'b0;
    w_ovf       = 1'b0;
    w_udf       = 1'b0;
    w_count_nxt = r_count;
    if (!RESET) begin
      w_rd_acc = rd && !r_empty;
      w_wr_acc = wr && (!r_full || rd);
      w_ovf    = wr && r_full && !rd;
      w_udf    = rd && r_empty;
      if (w_wr_acc && !w_rd_acc) begin
        w_count_nxt = r_count + 1'b1;
      end else if (w_rd_acc && !w_wr_acc) begin
        w_count_nxt = r_count - 1'b1;
      end
    end
  end

  // Write port of the storage array; no reset so the array maps onto RAM.
  always_ff @(posedge CLK) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= w_data;
    end
  end

  // Pointers wrap naturally modulo the depth; count disambiguates full vs empty.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy and status flags, all registered from the next-state count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_count        <= w_count_nxt;
      r_empty        <= (w_count_nxt == '0);
      r_full         <= (w_count_nxt == L_DEPTH);
      r_almost_empty <= (w_count_nxt <= L_AE);
      r_almost_full  <= (w_count_nxt >= L_AF);
      r_overflow     <= w_ovf;
      r_underflow    <= w_udf;
    end
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // Head word is always on the output; rd just acknowledges it.
      assign r_data = r_mem[r_rd_ptr];
    end else begin : g_registered
      logic [B-1:0] r_rd_data;
      // Registered read: capture the head word on an accepted read, hold otherwise.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_rd_data <= '0;
        end else if (w_rd_acc) begin
          r_rd_data <= r_mem[r_rd_ptr];
        end
      end
      assign r_data = r_rd_data;
    end
  endgenerate

  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
